// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline: resolves load-use, branch, jump and
// data-memory wait hazards, bounds memory waits with a halting timeout, counts stalls/flushes.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             ex_regwrite_i,
    input  logic             br_taken_ex_i,
    input  logic             jump_id_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_flush_o,
    output logic             exmem_we_o,
    output logic             memwb_flush_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StHalt
    } state_e;

    state_e           state_q;
    logic [WaitW-1:0] wait_cnt_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic mem_stall;
    logic load_use;
    logic rd_hits_rs;
    logic rd_hits_rt;

    assign mem_stall  = dmem_req_i & ~dmem_ready_i;
    assign rd_hits_rs = (ex_rd_i == id_rs_i);
    assign rd_hits_rt = id_uses_rt_i & (ex_rd_i == id_rt_i);
    assign load_use   = ex_memread_i & ex_regwrite_i & (ex_rd_i != 5'd0) &
                        (rd_hits_rs | rd_hits_rt);

    always_comb begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_we_o    = 1'b1;
        memwb_flush_o = 1'b0;
        if (rst_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            memwb_flush_o = 1'b1;
        end else if (state_q == StHalt || mem_stall) begin
            // Freeze everything upstream of MEM; a bubble drains into WB.
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            memwb_flush_o = 1'b1;
        end else if (br_taken_ex_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
        end else if (jump_id_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= WaitW'(1);
                    end
                end
                StMemWait: begin
                    // A withdrawn request ends the wait just like a completed one.
                    if (!mem_stall) begin
                        state_q    <= StRun;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WaitLast) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WaitW'(1);
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q    <= StRun;
                    wait_cnt_q <= '0;
                end
            endcase

            if (!pc_we_o && stall_cnt_q != CntMax) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((ifid_flush_o | idex_flush_o) && state_q != StHalt && flush_cnt_q != CntMax) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=8 and CNT_W=4 so that timeout and
// counter saturation are reachable in a few dozen cycles.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 4;

    // Control vector order: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] RSTV = 7'b0010101;
    localparam logic [6:0] MEMS = 7'b0000001;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] JMP  = 7'b1111010;

    logic clk;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_uses_rt, ex_memread, ex_regwrite, br_taken_ex, jump_id, dmem_req, dmem_ready;
    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0] ctl;

    int total = 0;
    int bad   = 0;

    assign ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush};

    pipeline_hazard_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .ex_rd_i      (ex_rd),
        .ex_memread_i (ex_memread),
        .ex_regwrite_i(ex_regwrite),
        .br_taken_ex_i(br_taken_ex),
        .jump_id_i    (jump_id),
        .dmem_req_i   (dmem_req),
        .dmem_ready_i (dmem_ready),
        .pc_we_o      (pc_we),
        .ifid_we_o    (ifid_we),
        .ifid_flush_o (ifid_flush),
        .idex_we_o    (idex_we),
        .idex_flush_o (idex_flush),
        .exmem_we_o   (exmem_we),
        .memwb_flush_o(memwb_flush),
        .halted_o     (halted),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rd = 5'd0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; br_taken_ex = 1'b0; jump_id = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs change on the falling edge; combinational checks land 1 time unit later.
    task automatic drive_edge();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        idle();
        rst = 1'b1;
        tick();
        drive_edge();
        rst = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd);
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        chk("reset_ctl", 32'(ctl), 32'(RSTV));
        tick();
        tick();
        drive_edge();
        rst = 1'b0;
        #1;
        chk("post_reset_ctl", 32'(ctl), 32'(NORM));
        chk("post_reset_stall", 32'(stall_cnt), 0);
        chk("post_reset_flush", 32'(flush_cnt), 0);
        chk("post_reset_halted", 32'(halted), 0);

        // Load-use on rs, then a load into $0 that must not stall.
        load(5'd5); id_rs = 5'd5;
        #1;
        chk("lu_rs_ctl", 32'(ctl), 32'(LU));
        tick();
        chk("lu_rs_stall", 32'(stall_cnt), 1);
        chk("lu_rs_flush", 32'(flush_cnt), 1);
        drive_edge();
        load(5'd0); id_rs = 5'd0;
        #1;
        chk("lu_r0_ctl", 32'(ctl), 32'(NORM));
        tick();
        chk("lu_r0_stall", 32'(stall_cnt), 1);

        // rt match counts only when the ID instruction reads rt.
        do_reset();
        load(5'd7); id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused", 32'(ctl), 32'(NORM));
        drive_edge();
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(ctl), 32'(LU));

        // Three-cycle memory wait then completion.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memwait_ctl", 32'(ctl), 32'(MEMS));
            tick();
            drive_edge();
        end
        dmem_ready = 1'b1;
        #1;
        chk("memdone_ctl", 32'(ctl), 32'(NORM));
        tick();
        chk("memdone_stall", 32'(stall_cnt), 3);
        chk("memdone_halted", 32'(halted), 0);
        drive_edge();
        idle();
        #1;
        chk("memdone_idle", 32'(ctl), 32'(NORM));

        // Request withdrawn mid-wait is treated as completion.
        do_reset();
        dmem_req = 1'b1;
        tick();
        drive_edge();
        dmem_req = 1'b0; jump_id = 1'b1;
        #1;
        chk("memdrop_jump", 32'(ctl), 32'(JMP));
        tick();
        chk("memdrop_stall", 32'(stall_cnt), 1);
        chk("memdrop_halted", 32'(halted), 0);

        // Timeout: the 8th consecutive wait cycle halts the pipeline.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("timeout_ctl", 32'(ctl), 32'(MEMS));
            tick();
            chk("timeout_halted", 32'(halted), (i == 8) ? 1 : 0);
            drive_edge();
        end
        dmem_ready = 1'b1;
        #1;
        chk("halt_ready_ctl", 32'(ctl), 32'(MEMS));
        tick();
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_stall", 32'(stall_cnt), 9);
        drive_edge();
        br_taken_ex = 1'b1; dmem_req = 1'b0;
        #1;
        chk("halt_branch_ctl", 32'(ctl), 32'(MEMS));
        tick();
        chk("halt_flush", 32'(flush_cnt), 0);
        drive_edge();
        rst = 1'b1;
        #1;
        chk("halt_rst_ctl", 32'(ctl), 32'(RSTV));
        tick();
        drive_edge();
        rst = 1'b0; idle();
        #1;
        chk("halt_clear_ctl", 32'(ctl), 32'(NORM));
        chk("halt_clear_halted", 32'(halted), 0);
        chk("halt_clear_stall", 32'(stall_cnt), 0);

        // Branch outranks load-use and jump; memory stall outranks branch.
        do_reset();
        br_taken_ex = 1'b1; jump_id = 1'b1; load(5'd9); id_rs = 5'd9;
        #1;
        chk("br_prio_ctl", 32'(ctl), 32'(BR));
        tick();
        chk("br_prio_flush", 32'(flush_cnt), 1);
        chk("br_prio_stall", 32'(stall_cnt), 0);
        do_reset();
        br_taken_ex = 1'b1; jump_id = 1'b1; load(5'd9); id_rs = 5'd9;
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("br_mem_ctl", 32'(ctl), 32'(MEMS));
        tick();
        drive_edge();
        dmem_ready = 1'b1;
        #1;
        chk("br_after_mem_ctl", 32'(ctl), 32'(BR));
        tick();
        chk("br_after_mem_flush", 32'(flush_cnt), 1);
        chk("br_after_mem_stall", 32'(stall_cnt), 1);

        // Jump alone.
        do_reset();
        jump_id = 1'b1;
        #1;
        chk("jump_ctl", 32'(ctl), 32'(JMP));

        // 20 load-use stalls saturate the 4-bit counters at 15.
        do_reset();
        load(5'd4); id_rt = 5'd4; id_uses_rt = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat_stall_14", 32'(stall_cnt), 14);
        end
        chk("sat_stall", 32'(stall_cnt), 15);
        chk("sat_flush", 32'(flush_cnt), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
